// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Runs the control sequence for one AES-128 encryption:
//   1. initial AddRoundKey with K0
//   2. NR rounds, each using the external round function (SubBytes/ShiftRows/
//      MixColumns) followed by an internal AddRoundKey with K[r]
// Round keys come from an external pre-expanded key RAM with a 1-cycle read
// latency. Only one block is in flight at a time.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     plaintext handshake, in_block = plaintext
//   out_valid/out_ready   ciphertext handshake, out_block = ciphertext (held)
//   key_rd/key_addr       key RAM read strobe/address
//   key_data              key RAM data, valid the cycle after key_rd
//   rf_state/rf_final     state and final-round flag to the round function
//   rf_result             combinational round-function result
//   busy                  a block is in flight
//   round                 current round index, 0 outside the round phase
//
// Configuration
//   AES_SEQ_ABORT_EN      adds input 'abort', which drops the block in flight
//                         and returns to idle on the next cycle.
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR     = 10,
    parameter int KEY_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef AES_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_block,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_block,
    output logic              key_rd,
    output logic [KEY_AW-1:0] key_addr,
    input  logic [127:0]      key_data,
    output logic [127:0]      rf_state,
    output logic              rf_final,
    input  logic [127:0]      rf_result,
    output logic              busy,
    output logic [KEY_AW-1:0] round
);

    localparam logic [KEY_AW-1:0] NR_C = KEY_AW'(NR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY0  = 3'd1,
        S_ARK0  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } fsm_t;

    function automatic logic [127:0] add_round_key(input logic [127:0] st,
                                                   input logic [127:0] rk);
        return st ^ rk;
    endfunction

    fsm_t              fsm_r, fsm_next_s;
    logic [127:0]      state_r, state_next_s;
    logic [127:0]      out_block_r, out_block_next_s;
    logic [KEY_AW-1:0] round_r, round_next_s;
    logic [KEY_AW-1:0] key_addr_r, key_addr_s;
    logic              key_rd_r, key_rd_s;
    logic              rf_final_r, rf_final_s;
    logic              in_ready_r, in_ready_s;
    logic              out_valid_r, out_valid_s;
    logic              busy_r, busy_s;
    logic              abort_s;

`ifdef AES_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state and datapath update for the block sequence
    always_comb begin
        fsm_next_s       = fsm_r;
        state_next_s     = state_r;
        out_block_next_s = out_block_r;
        round_next_s     = {KEY_AW{1'b0}};
        case (fsm_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_next_s = in_block;
                    fsm_next_s   = S_KEY0;
                end else begin
                    fsm_next_s   = S_IDLE;
                end
            end
            S_KEY0: begin
                fsm_next_s = S_ARK0;
            end
            S_ARK0: begin
                state_next_s = add_round_key(state_r, key_data);
                round_next_s = KEY_AW'(1);
                fsm_next_s   = S_ROUND;
            end
            S_ROUND: begin
                state_next_s = add_round_key(rf_result, key_data);
                if (round_r == NR_C) begin
                    out_block_next_s = add_round_key(rf_result, key_data);
                    fsm_next_s       = S_DONE;
                end else begin
                    round_next_s     = round_r + KEY_AW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_next_s = S_IDLE;
                end else begin
                    fsm_next_s = S_DONE;
                end
            end
            default: begin
                fsm_next_s = S_IDLE;
            end
        endcase
        // Abort overrides everything, including a pending out_ready in DONE
        if (abort_s && (fsm_r != S_IDLE)) begin
            fsm_next_s       = S_IDLE;
            state_next_s     = state_r;
            out_block_next_s = out_block_r;
            round_next_s     = {KEY_AW{1'b0}};
        end else begin
            fsm_next_s       = fsm_next_s;
        end
    end

    // Output decode from the next state so every output leaves a flop.
    // A round r issues the read of K[r+1]; the last round reads nothing.
    always_comb begin
        key_rd_s   = 1'b0;
        key_addr_s = {KEY_AW{1'b0}};
        rf_final_s = 1'b0;
        case (fsm_next_s)
            S_KEY0: begin
                key_rd_s   = 1'b1;
                key_addr_s = {KEY_AW{1'b0}};
            end
            S_ARK0: begin
                key_rd_s   = 1'b1;
                key_addr_s = KEY_AW'(1);
            end
            S_ROUND: begin
                if (round_next_s != NR_C) begin
                    key_rd_s   = 1'b1;
                    key_addr_s = round_next_s + KEY_AW'(1);
                end else begin
                    rf_final_s = 1'b1;
                end
            end
            default: begin
                key_rd_s = 1'b0;
            end
        endcase
        in_ready_s  = (fsm_next_s == S_IDLE);
        out_valid_s = (fsm_next_s == S_DONE);
        busy_s      = (fsm_next_s != S_IDLE);
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r       <= S_IDLE;
            state_r     <= 128'd0;
            out_block_r <= 128'd0;
            round_r     <= {KEY_AW{1'b0}};
            key_addr_r  <= {KEY_AW{1'b0}};
            key_rd_r    <= 1'b0;
            rf_final_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_next_s;
            state_r     <= state_next_s;
            out_block_r <= out_block_next_s;
            round_r     <= round_next_s;
            key_addr_r  <= key_addr_s;
            key_rd_r    <= key_rd_s;
            rf_final_r  <= rf_final_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_block = out_block_r;
    assign key_rd    = key_rd_r;
    assign key_addr  = key_addr_r;
    assign rf_state  = state_r;
    assign rf_final  = rf_final_r;
    assign busy      = busy_r;
    assign round     = round_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
// Models the key RAM (FIPS-197 expanded key) and a golden AES round function
// around the sequencer. Expected ciphertexts are queued when a block is
// accepted and checked by a separate output monitor.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    localparam int NR     = 10;
    localparam int KEY_AW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [127:0]      in_block;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      out_block;
    logic              key_rd;
    logic [KEY_AW-1:0] key_addr;
    logic [127:0]      key_data;
    logic [127:0]      rf_state;
    logic              rf_final;
    logic [127:0]      rf_result;
    logic              busy;
    logic [KEY_AW-1:0] round;
`ifdef AES_SEQ_ABORT_EN
    logic              abort;
`endif

    aes_round_sequencer #(.NR(NR), .KEY_AW(KEY_AW)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef AES_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .key_rd    (key_rd),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .rf_state  (rf_state),
        .rf_final  (rf_final),
        .rf_result (rf_result),
        .busy      (busy),
        .round     (round)
    );

    always #5 clk = ~clk;

    // FIPS-197 Appendix A expansion of 2b7e151628aed2a6abf7158809cf4f3c
    logic [127:0] keys [0:10];
    initial begin
        keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    end

    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;

    // ---------------- golden AES model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic fin);
        logic [7:0] a [16];
        logic [7:0] t [16];
        logic [7:0] c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[rw + 4*c] = a[rw + 4*((c + rw) % 4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                c0 = t[4*c]; c1 = t[4*c+1]; c2 = t[4*c+2]; c3 = t[4*c+3];
                t[4*c]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
                t[4*c+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
                t[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
                t[4*c+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ keys[0];
        for (int rr = 1; rr <= NR; rr++) s = aes_round(s, rr == NR) ^ keys[rr];
        return s;
    endfunction

    always_comb rf_result = aes_round(rf_state, rf_final);

    // Key RAM: 1-cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (key_rd && (int'(key_addr) <= NR)) key_data <= keys[key_addr];
        else key_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] ct;
        int           acc;
    } exp_t;
    exp_t         exp_q[$];
    logic [127:0] cur_exp;
    int           cyc = 0;
    int           acc_cnt = 0;
    int           last_acc = 0;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout (cycle %0d)", name, cyc);
    endtask

    // Cycle count, acceptance capture and scoreboard push
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            exp_q.delete();
`ifdef AES_SEQ_ABORT_EN
        end else if (abort && busy) begin
            exp_q.delete();
`endif
        end else if (in_valid && in_ready) begin
            exp_q.push_back('{ct: cur_exp, acc: cyc});
            acc_cnt  <= acc_cnt + 1;
            last_acc <= cyc;
        end
    end

    // Output monitor: pops on each new out_valid, checks value, latency, hold
    logic         prev_ov = 1'b0;
    logic [127:0] prev_ob = 128'd0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 128'(out_valid), 128'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_block", out_block, e.ct);
                chk("latency", 128'(cyc - e.acc), 128'd13);
            end
        end else if (out_valid && prev_ov) begin
            chk("out_block_hold", out_block, prev_ob);
            chk("in_ready_in_done", 128'(in_ready), 128'd0);
        end
        prev_ov = out_valid;
        prev_ob = out_block;
    end

    // ---------------- driver ----------------
    task automatic send(input logic [127:0] pt, input logic [127:0] ct, input bit hold);
        int n0;
        n0       = acc_cnt;
        in_block = pt;
        cur_exp  = ct;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && acc_cnt == n0; i++) @(negedge clk);
        if (acc_cnt == n0) timeout("accept");
        if (!hold) begin
            in_valid = 1'b0;
            in_block = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid || busy) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) timeout("drain");
    endtask

    task automatic wait_round(input int r);
        int k;
        k = 0;
        while (int'(round) != r && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) timeout("wait_round");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_key_rd"}, 128'(key_rd), 128'd0);
        chk({tag, "_key_addr"}, 128'(key_addr), 128'd0);
        chk({tag, "_rf_final"}, 128'(rf_final), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_round"}, 128'(round), 128'd0);
        chk({tag, "_out_block"}, out_block, 128'd0);
        chk({tag, "_rf_state"}, rf_state, 128'd0);
    endtask

    logic [127:0] ct2;
    int           a1, a2, k;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_block  = 128'd0;
        out_ready = 1'b1;
        cur_exp   = 128'd0;
`ifdef AES_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        ct2 = aes_encrypt(PT2);
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 block with cycle-by-cycle control trace (T+1..T+13)
        send(PT1, CT1, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            chk("trace_busy", 128'(busy), 128'd1);
            chk("trace_key_rd", 128'(key_rd), (i <= 11) ? 128'd1 : 128'd0);
            if (i <= 11) chk("trace_key_addr", 128'(key_addr), 128'(i - 1));
            chk("trace_rf_final", 128'(rf_final), (i == 12) ? 128'd1 : 128'd0);
            chk("trace_round", 128'(round), (i >= 3 && i <= 12) ? 128'(i - 2) : 128'd0);
            chk("trace_out_valid", 128'(out_valid), (i == 13) ? 128'd1 : 128'd0);
            @(negedge clk);
        end
        chk("post_busy", 128'(busy), 128'd0);
        chk("post_in_ready", 128'(in_ready), 128'd1);
        chk("post_key_rd", 128'(key_rd), 128'd0);
        drain();

        // Backpressure: 20 cycles held in DONE
        out_ready = 1'b0;
        send(PT2, ct2, 1'b0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) timeout("wait_out_valid");
        repeat (20) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_block", out_block, ct2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);

        // Back-to-back blocks with in_valid held
        send(PT1, CT1, 1'b1);
        a1 = last_acc;
        send(PT2, ct2, 1'b0);
        a2 = last_acc;
        chk("accept_period", 128'(a2 - a1), 128'd14);
        drain();

        // Reset during round 5 abandons the block
        send(PT1, CT1, 1'b0);
        wait_round(5);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send(PT1, CT1, 1'b0);
        drain();

`ifdef AES_SEQ_ABORT_EN
        // Abort in round 3
        send(PT2, ct2, 1'b0);
        wait_round(3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_round", 128'(round), 128'd0);
        chk("abort_key_rd", 128'(key_rd), 128'd0);
        chk("abort_out_block", out_block, CT1);
        repeat (20) @(negedge clk);
        send(PT1, CT1, 1'b0);
        drain();

        // Abort in DONE beats out_ready
        out_ready = 1'b0;
        send(PT2, ct2, 1'b0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) timeout("wait_out_valid_abort");
        out_ready = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done_out_valid", 128'(out_valid), 128'd0);
        chk("abort_done_in_ready", 128'(in_ready), 128'd1);
        chk("abort_done_out_block", out_block, ct2);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
